// File: rtl/axi_pkg.sv
// Shared AXI4 types and bus widths for the on-chip RAM responder and its burst-address helper.
`ifndef ID_BITS
`define ID_BITS 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package axi_pkg;
  localparam int ID_W   = `ID_BITS;
  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int LEN_W  = `LEN_BITS;
  localparam int SIZE_W = `SIZE_BITS;
  localparam int DATA_W = `DATA_WIDTH;
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address for one AXI channel, plus a flag for bursts this responder cannot serve.
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [SIZE_W-1:0] size_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              err_o
);
  logic [ADDR_W-1:0] step;

  always_comb begin
    step = '0;
    if (burst_i == INCR) step = ADDR_W'(1) << size_i;
    next_addr_o = addr_i + step;
    // Wider-than-bus beats and WRAP/reserved bursts are answered with SLVERR.
    err_o = (32'(size_i) > OFF_W) || ((burst_i != FIXED) && (burst_i != INCR));
  end
endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave terminating onto a word-addressed RAM; write (AW/W/B) and read (AR/R) FSMs run independently.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ID_W-1:0]   awid_i,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic [LEN_W-1:0]  awlen_i,
  input  logic [SIZE_W-1:0] awsize_i,
  input  logic [1:0]        awburst_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              wlast_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [ID_W-1:0]   bid_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic [ID_W-1:0]   arid_i,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic [LEN_W-1:0]  arlen_i,
  input  logic [SIZE_W-1:0] arsize_i,
  input  logic [1:0]        arburst_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [ID_W-1:0]   rid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rlast_o,
  output logic              rvalid_o,
  input  logic              rready_i
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // READY is held low until the first clock after reset release.
  logic rdy_en_q;

  wr_state_e         w_state_q, w_state_d;
  logic [ID_W-1:0]   aw_id_q;
  logic [ADDR_W-1:0] aw_addr_q, w_ba_addr, w_next_addr;
  logic [LEN_W-1:0]  aw_len_q, w_cnt_q;
  logic [SIZE_W-1:0] aw_size_q, w_ba_size;
  logic [1:0]        aw_burst_q, w_ba_burst, bresp_q;
  logic              aw_err_q, w_err, aw_hs, w_hs, b_hs, w_last_beat;

  rd_state_e         r_state_q, r_state_d;
  logic [ID_W-1:0]   ar_id_q;
  logic [ADDR_W-1:0] ar_addr_q, r_ba_addr, r_next_addr;
  logic [LEN_W-1:0]  ar_len_q, r_cnt_q;
  logic [SIZE_W-1:0] ar_size_q, r_ba_size;
  logic [1:0]        ar_burst_q, r_ba_burst, rresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ar_err_q, r_err, rlast_q, ar_hs, r_hs;

  assign awready_o = rdy_en_q && (w_state_q == W_IDLE);
  assign wready_o  = (w_state_q == W_DATA);
  assign bvalid_o  = (w_state_q == W_RESP);
  assign bid_o     = aw_id_q;
  assign bresp_o   = bresp_q;
  assign arready_o = rdy_en_q && (r_state_q == R_IDLE);
  assign rvalid_o  = (r_state_q == R_DATA);
  assign rid_o     = ar_id_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rlast_o   = rlast_q;

  assign aw_hs       = awvalid_i && awready_o;
  assign w_hs        = wvalid_i && wready_o;
  assign b_hs        = bvalid_o && bready_i;
  assign ar_hs       = arvalid_i && arready_o;
  assign r_hs        = rvalid_o && rready_i;
  assign w_last_beat = (w_cnt_q == aw_len_q);

  // In idle the helpers see the incoming request (for the error check); otherwise the latched burst.
  assign w_ba_addr  = (w_state_q == W_IDLE) ? awaddr_i  : aw_addr_q;
  assign w_ba_size  = (w_state_q == W_IDLE) ? awsize_i  : aw_size_q;
  assign w_ba_burst = (w_state_q == W_IDLE) ? awburst_i : aw_burst_q;
  assign r_ba_addr  = (r_state_q == R_IDLE) ? araddr_i  : ar_addr_q;
  assign r_ba_size  = (r_state_q == R_IDLE) ? arsize_i  : ar_size_q;
  assign r_ba_burst = (r_state_q == R_IDLE) ? arburst_i : ar_burst_q;

  axi_burst_addr u_wr_addr (
    .addr_i(w_ba_addr), .size_i(w_ba_size), .burst_i(w_ba_burst),
    .next_addr_o(w_next_addr), .err_o(w_err)
  );

  axi_burst_addr u_rd_addr (
    .addr_i(r_ba_addr), .size_i(r_ba_size), .burst_i(r_ba_burst),
    .next_addr_o(r_next_addr), .err_o(r_err)
  );

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs && rlast_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdy_en_q   <= 1'b0;
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      aw_err_q   <= 1'b0;
      w_cnt_q    <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      rdy_en_q  <= 1'b1;
      w_state_q <= w_state_d;
      if (aw_hs) begin
        aw_id_q    <= awid_i;
        aw_addr_q  <= awaddr_i;
        aw_len_q   <= awlen_i;
        aw_size_q  <= awsize_i;
        aw_burst_q <= awburst_i;
        aw_err_q   <= w_err;
        w_cnt_q    <= '0;
        bresp_q    <= w_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (w_hs) begin
        aw_addr_q <= w_next_addr;
        w_cnt_q   <= w_cnt_q + LEN_W'(1);
        // WLAST that disagrees with the beat count taints the response but not the data.
        if (wlast_i != w_last_beat) bresp_q <= RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_hs && !aw_err_q) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) mem[aw_addr_q[OFF_W +: IDX_W]][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_err_q   <= 1'b0;
      r_cnt_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        ar_id_q    <= arid_i;
        ar_addr_q  <= araddr_i;
        ar_len_q   <= arlen_i;
        ar_size_q  <= arsize_i;
        ar_burst_q <= arburst_i;
        ar_err_q   <= r_err;
        r_cnt_q    <= '0;
        rdata_q    <= r_err ? '0 : mem[araddr_i[OFF_W +: IDX_W]];
        rresp_q    <= r_err ? RESP_SLVERR : RESP_OKAY;
        rlast_q    <= (arlen_i == '0);
      end else if (r_hs && !rlast_q) begin
        // Fetch the next beat in the handshake cycle so a held RREADY streams one beat per clock.
        ar_addr_q <= r_next_addr;
        r_cnt_q   <= r_cnt_q + LEN_W'(1);
        rdata_q   <= ar_err_q ? '0 : mem[r_next_addr[OFF_W +: IDX_W]];
        rlast_q   <= ((r_cnt_q + LEN_W'(1)) == ar_len_q);
      end
    end
  end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: single, INCR, FIXED, strobe, error, WLAST and mid-burst reset scenarios.
module tb_axi_mem_slave;
  import axi_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ID_W-1:0]   awid, arid, bid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [LEN_W-1:0]  awlen, arlen;
  logic [SIZE_W-1:0] awsize, arsize;
  logic [1:0]        awburst, arburst, bresp, rresp;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [STRB_W-1:0] wstrb;

  always #5 clk = ~clk;

  axi_mem_slave #(.MEM_WORDS(1024)) dut (
    .clk_i(clk), .rst_i(rst),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
    .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid),
    .rready_i(rready)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] wbuf [16];
  logic [STRB_W-1:0] sbuf [16];
  logic [DATA_W-1:0] rbuf [16];
  logic [1:0]        rrsp [16];
  logic              rlst [16];
  logic [ID_W-1:0]   bid_cap, rid_cap;
  logic [1:0]        bresp_cap;
  int                stall_bad, stall_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input int id, input logic [ADDR_W-1:0] a, input int len, input int size,
                         input logic [1:0] burst);
    bit ok = 1'b0;
    awid = ID_W'(id); awaddr = a; awlen = LEN_W'(len); awsize = SIZE_W'(size); awburst = burst;
    awvalid = 1'b1;
    for (int g = 0; g < 100 && !ok; g++) begin
      ok = awready;
      tick();
    end
    awvalid = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL aw_timeout: got no AWREADY in 100 cycles, required a handshake");
    end
  endtask

  task automatic send_ar(input int id, input logic [ADDR_W-1:0] a, input int len, input int size,
                         input logic [1:0] burst);
    bit ok = 1'b0;
    arid = ID_W'(id); araddr = a; arlen = LEN_W'(len); arsize = SIZE_W'(size); arburst = burst;
    arvalid = 1'b1;
    for (int g = 0; g < 100 && !ok; g++) begin
      ok = arready;
      tick();
    end
    arvalid = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL ar_timeout: got no ARREADY in 100 cycles, required a handshake");
    end
  endtask

  task automatic send_w(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s, input logic last);
    bit ok = 1'b0;
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    for (int g = 0; g < 100 && !ok; g++) begin
      ok = wready;
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL w_timeout: got no WREADY in 100 cycles, required a handshake");
    end
  endtask

  task automatic write_burst(input int id, input logic [ADDR_W-1:0] a, input int len, input int size,
                             input logic [1:0] burst, input bit bad_last);
    bit ok = 1'b0;
    send_aw(id, a, len, size, burst);
    for (int i = 0; i <= len; i++) send_w(wbuf[i], sbuf[i], bad_last ? (i == 0) : (i == len));
    bready = 1'b1;
    for (int g = 0; g < 100 && !ok; g++) begin
      ok = bvalid;
      bid_cap = bid; bresp_cap = bresp;
      tick();
    end
    bready = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL b_timeout: got no BVALID in 100 cycles, required a response");
    end
  endtask

  task automatic read_burst(input int id, input logic [ADDR_W-1:0] a, input int len, input int size,
                            input logic [1:0] burst, input bit toggle);
    int beat = 0;
    int g = 0;
    bit stalled = 1'b0;
    logic [DATA_W-1:0] pd;
    logic [ID_W-1:0] pi;
    logic [1:0] pr;
    logic pl;
    stall_bad = 0; stall_cnt = 0;
    send_ar(id, a, len, size, burst);
    while (beat <= len && g < 200) begin
      rready = toggle ? g[0] : 1'b1;
      if (stalled && rvalid && (rdata !== pd || rid !== pi || rresp !== pr || rlast !== pl))
        stall_bad++;
      stalled = rvalid && !rready;
      if (stalled) stall_cnt++;
      pd = rdata; pi = rid; pr = rresp; pl = rlast;
      if (rvalid && rready) begin
        rbuf[beat] = rdata; rrsp[beat] = rresp; rlst[beat] = rlast; rid_cap = rid;
        beat++;
      end
      tick();
      g++;
    end
    rready = 1'b0;
    if (beat <= len) begin
      n_vec++; n_err++;
      $display("FAIL r_timeout: got %0d beats, required %0d", beat, len + 1);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_vec++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_handshake: got aw/w/b/ar/r/last=%b, required 000000",
               {awready, wready, bvalid, arready, rvalid, rlast});
    end
    n_vec++;
    if (bid !== '0 || rid !== '0 || rdata !== '0 || bresp !== '0 || rresp !== '0) begin
      n_err++;
      $display("FAIL reset_fields: got bid=%0d rid=%0d rdata=%h bresp=%0d rresp=%0d, required all 0",
               bid, rid, rdata, bresp, rresp);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (awready !== 1'b1 || arready !== 1'b1 || wready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got awready=%b arready=%b wready=%b, required 1 1 0",
               awready, arready, wready);
    end
  endtask

  task automatic test_single();
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    write_burst(3, 32'h10, 0, 2, INCR, 1'b0);
    n_vec++;
    if (bid_cap !== 4'd3 || bresp_cap !== RESP_OKAY) begin
      n_err++;
      $display("FAIL single_b: got bid=%0d bresp=%0d, required bid=3 bresp=0", bid_cap, bresp_cap);
    end
    read_burst(3, 32'h10, 0, 2, INCR, 1'b0);
    n_vec++;
    if (rbuf[0] !== 32'hDEADBEEF || rlst[0] !== 1'b1 || rid_cap !== 4'd3 || rrsp[0] !== RESP_OKAY) begin
      n_err++;
      $display("FAIL single_r: got rdata=%h rlast=%b rid=%0d rresp=%0d, required deadbeef 1 3 0",
               rbuf[0], rlst[0], rid_cap, rrsp[0]);
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 8; i++) begin wbuf[i] = DATA_W'(i + 1); sbuf[i] = 4'hF; end
    write_burst(5, 32'h100, 7, 2, INCR, 1'b0);
    n_vec++;
    if (bresp_cap !== RESP_OKAY) begin
      n_err++;
      $display("FAIL incr_bresp: got %0d, required 0", bresp_cap);
    end
    read_burst(5, 32'h100, 7, 2, INCR, 1'b1);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (rbuf[i] !== DATA_W'(i + 1) || rlst[i] !== (i == 7)) begin
        n_err++;
        $display("FAIL incr_beat%0d: got data=%h last=%b, required data=%h last=%b",
                 i, rbuf[i], rlst[i], DATA_W'(i + 1), (i == 7));
      end
    end
    n_vec++;
    if (stall_bad !== 0 || stall_cnt == 0) begin
      n_err++;
      $display("FAIL incr_stall: got %0d changes in %0d stalls, required 0 changes in >0 stalls",
               stall_bad, stall_cnt);
    end
  endtask

  task automatic test_fixed();
    wbuf[0] = 32'h44444444; wbuf[1] = 32'h48484848; wbuf[2] = 32'h4C4C4C4C;
    for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
    write_burst(1, 32'h44, 2, 2, INCR, 1'b0);
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    write_burst(2, 32'h40, 3, 2, FIXED, 1'b0);
    read_burst(2, 32'h40, 0, 2, INCR, 1'b0);
    n_vec++;
    if (rbuf[0] !== 32'hD) begin
      n_err++;
      $display("FAIL fixed_word40: got %h, required 0000000d", rbuf[0]);
    end
    read_burst(2, 32'h44, 2, 2, INCR, 1'b0);
    n_vec++;
    if (rbuf[0] !== 32'h44444444 || rbuf[1] !== 32'h48484848 || rbuf[2] !== 32'h4C4C4C4C) begin
      n_err++;
      $display("FAIL fixed_neighbours: got %h %h %h, required 44444444 48484848 4c4c4c4c",
               rbuf[0], rbuf[1], rbuf[2]);
    end
  endtask

  task automatic test_strobe();
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    write_burst(4, 32'h200, 0, 2, INCR, 1'b0);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
    write_burst(4, 32'h200, 0, 0, INCR, 1'b0);
    read_burst(4, 32'h200, 0, 0, INCR, 1'b0);
    n_vec++;
    if (rbuf[0] !== 32'h11BB33DD) begin
      n_err++;
      $display("FAIL strobe_merge: got %h, required 11bb33dd", rbuf[0]);
    end
  endtask

  task automatic test_err();
    wbuf[0] = 32'h30303030; wbuf[1] = 32'h34343434; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    write_burst(7, 32'h300, 1, 2, INCR, 1'b0);
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hFFFFFFFF; sbuf[i] = 4'hF; end
    write_burst(9, 32'h300, 3, 2, WRAP, 1'b0);
    n_vec++;
    if (bresp_cap !== RESP_SLVERR || bid_cap !== 4'd9) begin
      n_err++;
      $display("FAIL err_wrap_b: got bresp=%0d bid=%0d, required bresp=2 bid=9", bresp_cap, bid_cap);
    end
    read_burst(7, 32'h300, 1, 2, INCR, 1'b0);
    n_vec++;
    if (rbuf[0] !== 32'h30303030 || rbuf[1] !== 32'h34343434) begin
      n_err++;
      $display("FAIL err_wrap_mem: got %h %h, required 30303030 34343434", rbuf[0], rbuf[1]);
    end
    read_burst(8, 32'h300, 1, 3, INCR, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (rbuf[i] !== '0 || rrsp[i] !== RESP_SLVERR || rlst[i] !== (i == 1)) begin
        n_err++;
        $display("FAIL err_size_beat%0d: got data=%h resp=%0d last=%b, required 0 2 %b",
                 i, rbuf[i], rrsp[i], rlst[i], (i == 1));
      end
    end
  endtask

  task automatic test_wlast();
    wbuf[0] = 32'h1111; wbuf[1] = 32'h2222; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    write_burst(10, 32'h600, 1, 2, INCR, 1'b1);
    n_vec++;
    if (bresp_cap !== RESP_SLVERR) begin
      n_err++;
      $display("FAIL wlast_bresp: got %0d, required 2", bresp_cap);
    end
    read_burst(10, 32'h600, 1, 2, INCR, 1'b0);
    n_vec++;
    if (rbuf[0] !== 32'h1111 || rbuf[1] !== 32'h2222) begin
      n_err++;
      $display("FAIL wlast_data: got %h %h, required 00001111 00002222", rbuf[0], rbuf[1]);
    end
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    send_aw(1, 32'h500, 3, 2, INCR);
    send_w(32'h77777777, 4'hF, 1'b0);
    send_ar(2, 32'h100, 7, 2, INCR);
    rready = 1'b1;
    for (int g = 0; g < 50 && beats < 3; g++) begin
      if (rvalid) beats++;
      tick();
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (rvalid !== 1'b0 || bvalid !== 1'b0 || wready !== 1'b0 || beats != 3) begin
      n_err++;
      $display("FAIL midrst_abort: got rvalid=%b bvalid=%b wready=%b beats=%0d, required 0 0 0 3",
               rvalid, bvalid, wready, beats);
    end
    rready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (awready !== 1'b1 || arready !== 1'b1 || rvalid !== 1'b0 || bvalid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_idle: got awready=%b arready=%b rvalid=%b bvalid=%b, required 1 1 0 0",
               awready, arready, rvalid, bvalid);
    end
    wbuf[0] = 32'h5A5AA5A5; sbuf[0] = 4'hF;
    write_burst(6, 32'h500, 0, 2, INCR, 1'b0);
    read_burst(6, 32'h500, 0, 2, INCR, 1'b0);
    n_vec++;
    if (bid_cap !== 4'd6 || bresp_cap !== RESP_OKAY || rbuf[0] !== 32'h5A5AA5A5 || rid_cap !== 4'd6) begin
      n_err++;
      $display("FAIL midrst_after: got bid=%0d bresp=%0d rdata=%h rid=%0d, required 6 0 5a5aa5a5 6",
               bid_cap, bresp_cap, rbuf[0], rid_cap);
    end
  endtask

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_single();
    test_incr();
    test_fixed();
    test_strobe();
    test_err();
    test_wlast();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
